// File: rtl/v_lsu_mem_ctrl.sv
// v_lsu_mem_ctrl
// Sequencer and arbiter for the four 32-bit data-memory banks shared by the
// vector load path and the vector store path. One whole-register-group
// request is accepted at a time, then walked one 128-bit beat per cycle
// (one 32-bit word per bank).
//
// Ports:
//   clk, nrst                 clock (rising edge), async active-low reset
//   ld_valid/ld_ready         load request handshake; ready only in IDLE
//   ld_addr, ld_lmul          load base word address and LMUL encoding
//   st_valid/st_ready         store request handshake; ready only in IDLE
//   st_addr, st_lmul, st_data store base address, LMUL, 512-bit data
//   mem_addr0..3              bank word addresses (same value on all banks)
//   mem_we                    per-bank write enable, bit b = bank b
//   mem_wdata0..3             bank write data
//   mem_rdata0..3             bank read data, valid RD_LAT cycles after addr
//   ld_data, ld_done          assembled load result and its one-cycle pulse
//   st_done                   one-cycle pulse after the last store beat
//   busy                      controller is not idle
module v_lsu_mem_ctrl #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_lmul,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [2:0]        st_lmul,
  input  logic [511:0]      st_data,
  output logic [ADDR_W-1:0] mem_addr0,
  output logic [ADDR_W-1:0] mem_addr1,
  output logic [ADDR_W-1:0] mem_addr2,
  output logic [ADDR_W-1:0] mem_addr3,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata0,
  output logic [31:0]       mem_wdata1,
  output logic [31:0]       mem_wdata2,
  output logic [31:0]       mem_wdata3,
  input  logic [31:0]       mem_rdata0,
  input  logic [31:0]       mem_rdata1,
  input  logic [31:0]       mem_rdata2,
  input  logic [31:0]       mem_rdata3,
  output logic [511:0]      ld_data,
  output logic              ld_done,
  output logic              st_done,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    LD_ISSUE,
    LD_DRAIN,
    LD_DONE,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t            state;
  logic              ptr_st;     // 0: load wins a tie, 1: store wins a tie
  logic [1:0]        beat;       // beat currently on the bank address bus
  logic [1:0]        beat_nx;
  logic [1:0]        last_beat;  // N-1
  logic [1:0]        cap_idx;    // next 128-bit ld_data slot to fill
  logic [RD_LAT-1:0] rd_pend;    // issued-read pipeline, oldest in MSB
  logic [ADDR_W-1:0] addr_q;
  logic [127:0]      wbeat;
  logic [383:0]      st_buf;     // beats 1..3; beat 0 goes straight to wbeat

  // Encodings other than 001/010 (including reserved ones) mean one beat.
  function automatic logic [1:0] last_of(input logic [2:0] lmul);
    case (lmul)
      3'b001:  return 2'd1;
      3'b010:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign beat_nx = beat + 2'd1;

  assign ld_ready = nrst && (state == IDLE) && ld_valid && (!st_valid || !ptr_st);
  assign st_ready = nrst && (state == IDLE) && st_valid && (!ld_valid || ptr_st);
  assign busy     = (state != IDLE);

  assign mem_addr0  = addr_q;
  assign mem_addr1  = addr_q;
  assign mem_addr2  = addr_q;
  assign mem_addr3  = addr_q;
  assign mem_wdata0 = wbeat[31:0];
  assign mem_wdata1 = wbeat[63:32];
  assign mem_wdata2 = wbeat[95:64];
  assign mem_wdata3 = wbeat[127:96];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      ptr_st    <= 1'b0;
      beat      <= '0;
      last_beat <= '0;
      cap_idx   <= '0;
      rd_pend   <= '0;
      addr_q    <= '0;
      wbeat     <= '0;
      st_buf    <= '0;
      mem_we    <= '0;
      ld_data   <= '0;
      ld_done   <= 1'b0;
      st_done   <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      st_done <= 1'b0;
      // Each LD_ISSUE cycle launches one bank read; it returns RD_LAT
      // edges later. The single LD_DRAIN cycle assumes RD_LAT == 1.
      rd_pend <= RD_LAT'({rd_pend, state == LD_ISSUE});

      if (rd_pend[RD_LAT-1]) begin
        ld_data[128*cap_idx +: 128] <= {mem_rdata3, mem_rdata2, mem_rdata1, mem_rdata0};
        cap_idx <= cap_idx + 2'd1;
      end

      case (state)
        IDLE: begin
          if (ld_ready) begin
            state     <= LD_ISSUE;
            ptr_st    <= 1'b1;
            addr_q    <= ld_addr;
            beat      <= '0;
            cap_idx   <= '0;
            last_beat <= last_of(ld_lmul);
            for (int unsigned k = 0; k < 4; k++) begin
              if (k > 32'(last_of(ld_lmul))) ld_data[128*k +: 128] <= '0;
            end
          end else if (st_ready) begin
            state     <= ST_WRITE;
            ptr_st    <= 1'b0;
            addr_q    <= st_addr;
            beat      <= '0;
            last_beat <= last_of(st_lmul);
            mem_we    <= '1;
            wbeat     <= st_data[127:0];
            st_buf    <= st_data[511:128];
          end
        end
        LD_ISSUE: begin
          if (beat == last_beat) begin
            state  <= LD_DRAIN;
            addr_q <= '0;
          end else begin
            beat   <= beat_nx;
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        LD_DRAIN: begin
          state   <= LD_DONE;
          ld_done <= 1'b1;
        end
        LD_DONE: state <= IDLE;
        ST_WRITE: begin
          if (beat == last_beat) begin
            state   <= ST_DONE;
            st_done <= 1'b1;
            mem_we  <= '0;
            addr_q  <= '0;
            wbeat   <= '0;
          end else begin
            beat   <= beat_nx;
            addr_q <= addr_q + ADDR_W'(1);
            // st_buf starts at beat 1, so beat k+1 lives at st_buf slot k.
            wbeat  <= st_buf[128*beat +: 128];
          end
        end
        ST_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v_lsu_mem_ctrl.sv
module tb_v_lsu_mem_ctrl;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [13:0]   ld_addr = '0;
  logic [2:0]    ld_lmul = '0;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [13:0]   st_addr = '0;
  logic [2:0]    st_lmul = '0;
  logic [511:0]  st_data = '0;
  logic [13:0]   mem_addr0, mem_addr1, mem_addr2, mem_addr3;
  logic [3:0]    mem_we;
  logic [31:0]   mem_wdata0, mem_wdata1, mem_wdata2, mem_wdata3;
  logic [31:0]   mem_rdata0 = '0, mem_rdata1 = '0, mem_rdata2 = '0, mem_rdata3 = '0;
  logic [511:0]  ld_data;
  logic          ld_done, st_done, busy;

  int checks = 0;
  int failures = 0;

  v_lsu_mem_ctrl #(.ADDR_W(14), .RD_LAT(1)) dut (
    .clk(clk), .nrst(nrst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_lmul(ld_lmul),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_lmul(st_lmul),
    .st_data(st_data),
    .mem_addr0(mem_addr0), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_addr3(mem_addr3),
    .mem_we(mem_we),
    .mem_wdata0(mem_wdata0), .mem_wdata1(mem_wdata1), .mem_wdata2(mem_wdata2), .mem_wdata3(mem_wdata3),
    .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2), .mem_rdata3(mem_rdata3),
    .ld_data(ld_data), .ld_done(ld_done), .st_done(st_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bank model: one-cycle read latency, bank b returns {b, 14'b0, addr}.
  always @(posedge clk) begin
    mem_rdata0 <= {4'd0, 14'd0, mem_addr0};
    mem_rdata1 <= {4'd1, 14'd0, mem_addr1};
    mem_rdata2 <= {4'd2, 14'd0, mem_addr2};
    mem_rdata3 <= {4'd3, 14'd0, mem_addr3};
  end

  typedef struct {
    bit          is_ld;
    logic [13:0] addr;
    logic [2:0]  lmul;
    int          exp_n;     // beats
    int          exp_done;  // cycle of the done pulse, handshake edge = cycle 0
    logic [31:0] dbase;     // store word i = dbase + i
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_slot(input logic [13:0] a);
    return {4'd3, 14'd0, a, 4'd2, 14'd0, a, 4'd1, 14'd0, a, 4'd0, 14'd0, a};
  endfunction

  function automatic logic [511:0] mk_data(input logic [31:0] base);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = base + 32'(i);
    return d;
  endfunction

  // Raise valid, wait (bounded) for ready, then step past the handshake edge.
  task automatic handshake(input bit is_ld, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = is_ld ? ld_ready : st_ready;
    end
    chk(is_ld ? "ld_handshake" : "st_handshake", 512'(ok), 512'(1));
    if (ok) @(posedge clk);
    #1;
    ld_valid = 1'b0;
    st_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    bit ok;
    bit active;
    logic [511:0] d;
    logic [511:0] exp_ld;
    logic [127:0] exp_w;
    logic [13:0]  a;
    d = mk_data(v.dbase);
    if (v.is_ld) begin
      ld_addr = v.addr; ld_lmul = v.lmul; ld_valid = 1'b1;
    end else begin
      st_addr = v.addr; st_lmul = v.lmul; st_data = d; st_valid = 1'b1;
    end
    handshake(v.is_ld, ok);
    if (!ok) return;
    // Request fields change after the handshake and must be ignored.
    ld_addr = 14'($urandom); ld_lmul = 3'b010;
    st_addr = 14'($urandom); st_lmul = 3'b010; st_data = ~d;
    for (int c = 1; c <= v.exp_done; c++) begin
      @(negedge clk);
      a = v.addr + 14'(c - 1);
      active = (c <= v.exp_n);
      exp_w = '0;
      if (active && !v.is_ld) exp_w = d[128*(c-1) +: 128];
      chk("busy", 512'(busy), 512'(1));
      chk("mem_addr", {mem_addr3, mem_addr2, mem_addr1, mem_addr0},
          active ? {a, a, a, a} : 56'd0);
      chk("mem_we", 512'(mem_we), (active && !v.is_ld) ? 512'hF : 512'h0);
      chk("mem_wdata", {mem_wdata3, mem_wdata2, mem_wdata1, mem_wdata0}, exp_w);
      chk("ld_done", 512'(ld_done), 512'(v.is_ld && c == v.exp_done));
      chk("st_done", 512'(st_done), 512'(!v.is_ld && c == v.exp_done));
    end
    if (v.is_ld) begin
      exp_ld = '0;
      for (int k = 0; k < 4; k++)
        if (k < v.exp_n) exp_ld[128*k +: 128] = exp_slot(v.addr + 14'(k));
      chk("ld_data", ld_data, exp_ld);
    end
    @(negedge clk);
    chk("idle_after_done", 512'(busy), 512'(0));
  endtask

  initial begin
    bit ok;
    int gcyc[8];
    bit gtyp[8];
    int ng;
    int exp_cyc[5];
    bit exp_typ[5];
    vec_t rv;

    vecs[0] = '{1'b1, 14'h0010, 3'b000, 1, 3, 32'h0};
    vecs[1] = '{1'b1, 14'h3FFE, 3'b010, 4, 6, 32'h0};
    vecs[2] = '{1'b0, 14'h0100, 3'b001, 2, 3, 32'h0};
    vecs[3] = '{1'b1, 14'h0123, 3'b101, 1, 3, 32'h0};
    vecs[4] = '{1'b0, 14'h3FFF, 3'b010, 4, 5, 32'h0000_1000};
    vecs[5] = '{1'b1, 14'h0200, 3'b001, 2, 4, 32'h0};
    vecs[6] = '{1'b0, 14'h0050, 3'b111, 1, 2, 32'h0000_00A0};
    vecs[7] = '{1'b1, 14'h3FFF, 3'b011, 1, 3, 32'h0};

    // Reset state
    #12;
    chk("rst_addr", {mem_addr3, mem_addr2, mem_addr1, mem_addr0}, 512'h0);
    chk("rst_we", 512'(mem_we), 512'h0);
    chk("rst_wdata", {mem_wdata3, mem_wdata2, mem_wdata1, mem_wdata0}, 512'h0);
    chk("rst_ld_data", ld_data, 512'h0);
    chk("rst_flags", {ld_ready, st_ready, ld_done, st_done, busy}, 512'h0);
    @(negedge clk);
    nrst = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Arbitration: both requesters held valid from reset.
    @(negedge clk);
    nrst = 1'b0;
    ld_addr = 14'h0020; ld_lmul = 3'b000; ld_valid = 1'b1;
    st_addr = 14'h0030; st_lmul = 3'b000; st_data = mk_data(32'h77); st_valid = 1'b1;
    #1;
    chk("rst_ready_gate", {ld_ready, st_ready}, 512'h0);
    @(negedge clk);
    nrst = 1'b1;
    ng = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("ready_exclusive", 512'(ld_ready & st_ready), 512'h0);
      if ((ld_ready || st_ready) && ng < 8) begin
        gcyc[ng] = c;
        gtyp[ng] = st_ready;
        ng++;
      end
      @(negedge clk);
    end
    ld_valid = 1'b0;
    st_valid = 1'b0;
    exp_cyc = '{0, 4, 7, 11, 14};
    exp_typ = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    chk("grant_count", 512'(ng >= 5), 512'(1));
    for (int i = 0; i < 5 && i < ng; i++) begin
      chk("grant_type", 512'(gtyp[i]), 512'(exp_typ[i]));
      chk("grant_cycle", 512'(gcyc[i]), 512'(exp_cyc[i]));
    end
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
    chk("arb_settle", 512'(ok), 512'(1));

    // Reset in cycle 2 of a 4-beat load.
    ld_addr = 14'h00AB; ld_lmul = 3'b010; ld_valid = 1'b1;
    handshake(1'b1, ok);
    @(negedge clk);
    chk("mid_cycle1_addr", 512'(mem_addr0), 512'h00AB);
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk("mid_rst_addr", {mem_addr3, mem_addr2, mem_addr1, mem_addr0}, 512'h0);
    chk("mid_rst_we_wdata", {mem_we, mem_wdata3, mem_wdata2, mem_wdata1, mem_wdata0}, 512'h0);
    chk("mid_rst_ld_data", ld_data, 512'h0);
    chk("mid_rst_flags", {ld_ready, st_ready, ld_done, st_done, busy}, 512'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", 512'({ld_done, busy}), 512'h0);
    end
    nrst = 1'b1;
    rv = '{1'b1, 14'h00AB, 3'b010, 4, 6, 32'h0};
    run_op(rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
